// File: rtl/seq_shift_unit.sv
// seq_shift_unit: serial shifter that moves one bit position per clock, with valid/ready handshakes on both sides.
// Build macro SHIFT_ROTATE_EN enables ROL/ROR on codes 100/101; otherwise those codes report shift_err.
module seq_shift_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic                  src_sel,
    input  logic [2:0]            shift_fun,
    input  logic [AMT_WIDTH-1:0]  shift_amt,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  shift_en,
    output logic [DATA_WIDTH-1:0] shift_out,
    output logic                  carry_flag,
    output logic                  zero_flag,
    output logic                  shift_err
);
    // state | meaning
    // IDLE  | waiting for a request; in_ready follows shift_en
    // BUSY  | shifting one position per clock until the count reaches zero
    // DONE  | result and flags held until out_ready (or shift_en drops)
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [AMT_WIDTH-1:0] LP_W  = AMT_WIDTH'(DATA_WIDTH);
    localparam logic [2:0]           F_SRL = 3'b000;
    localparam logic [2:0]           F_SLL = 3'b001;
    localparam logic [2:0]           F_SRA = 3'b010;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0]           F_ROL = 3'b100;
    localparam logic [2:0]           F_ROR = 3'b101;
`endif

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [AMT_WIDTH-1:0]  r_cnt;
    logic [2:0]            r_fun;
    logic                  r_carry;
    logic                  r_zero;
    logic                  r_err;
    logic                  r_out_valid;
    logic                  r_idle_rdy;

    logic [DATA_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_step;
    logic                  w_eject;
    logic                  w_legal;
    logic                  w_accept;
    logic [AMT_WIDTH-1:0]  w_eff_cnt;
    logic [AMT_WIDTH-1:0]  w_clamp;
`ifdef SHIFT_ROTATE_EN
    logic                  w_is_rot;
    logic [AMT_WIDTH-1:0]  w_mod;
`endif

    // r_idle_rdy stays low through reset so in_ready cannot rise before the first edge after release
    assign in_ready   = r_idle_rdy & shift_en;
    assign w_accept   = in_valid & in_ready;
    assign w_operand  = src_sel ? in2 : in1;
    assign out_valid  = r_out_valid;
    assign shift_out  = r_data;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign shift_err  = r_err;
    assign w_clamp    = (shift_amt > LP_W) ? LP_W : shift_amt;

`ifdef SHIFT_ROTATE_EN
    assign w_mod     = shift_amt % LP_W;
    assign w_eff_cnt = w_is_rot ? w_mod : w_clamp;
`else
    assign w_eff_cnt = w_clamp;
`endif

    always_comb begin
        w_legal = 1'b0;
`ifdef SHIFT_ROTATE_EN
        w_is_rot = 1'b0;
`endif
        case (shift_fun)
            F_SRL, F_SLL, F_SRA: w_legal = 1'b1;
`ifdef SHIFT_ROTATE_EN
            F_ROL, F_ROR: begin
                w_legal  = 1'b1;
                w_is_rot = 1'b1;
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // One-position step; w_eject is the bit leaving the word this cycle
    always_comb begin
        w_step  = r_data;
        w_eject = 1'b0;
        case (r_fun)
            F_SRL: begin
                w_step  = {1'b0, r_data[DATA_WIDTH-1:1]};
                w_eject = r_data[0];
            end
            F_SLL: begin
                w_step  = {r_data[DATA_WIDTH-2:0], 1'b0};
                w_eject = r_data[DATA_WIDTH-1];
            end
            F_SRA: begin
                w_step  = {r_data[DATA_WIDTH-1], r_data[DATA_WIDTH-1:1]};
                w_eject = r_data[0];
            end
`ifdef SHIFT_ROTATE_EN
            F_ROL: begin
                w_step  = {r_data[DATA_WIDTH-2:0], r_data[DATA_WIDTH-1]};
                w_eject = r_data[DATA_WIDTH-1];
            end
            F_ROR: begin
                w_step  = {r_data[0], r_data[DATA_WIDTH-1:1]};
                w_eject = r_data[0];
            end
`endif
            default: begin
                w_step  = r_data;
                w_eject = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_cnt       <= '0;
            r_fun       <= 3'b000;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_idle_rdy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idle_rdy <= 1'b1;
                    if (w_accept) begin
                        r_fun      <= shift_fun;
                        r_carry    <= 1'b0;
                        r_idle_rdy <= 1'b0;
                        if (!w_legal) begin
                            r_data      <= '0;
                            r_err       <= 1'b1;
                            r_zero      <= 1'b1;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_eff_cnt == '0) begin
                            r_data      <= w_operand;
                            r_err       <= 1'b0;
                            r_zero      <= (w_operand == '0);
                            r_cnt       <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_data  <= w_operand;
                            r_err   <= 1'b0;
                            r_zero  <= 1'b0;
                            r_cnt   <= w_eff_cnt;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!shift_en) begin
                        r_state    <= S_IDLE;
                        r_idle_rdy <= 1'b1;
                    end else begin
                        r_data  <= w_step;
                        r_carry <= w_eject;
                        r_cnt   <= r_cnt - AMT_WIDTH'(1);
                        if (r_cnt == AMT_WIDTH'(1)) begin
                            r_zero      <= (w_step == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!shift_en || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idle_rdy  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_idle_rdy  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: random requests scored against an arithmetic model of the shift rules,
// with directed corner cases, aborts via shift_en and a mid-operation reset.
module tb_seq_shift_unit;
    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic          src_sel = 1'b0;
    logic [2:0]    shift_fun = 3'b000;
    logic [AW-1:0] shift_amt = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          shift_en = 1'b1;
    logic [W-1:0]  shift_out;
    logic          carry_flag;
    logic          zero_flag;
    logic          shift_err;

    seq_shift_unit #(.DATA_WIDTH(W), .AMT_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .src_sel(src_sel),
        .shift_fun(shift_fun), .shift_amt(shift_amt), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .shift_en(shift_en), .shift_out(shift_out), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .shift_err(shift_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         carry;
        logic         zero;
        logic         err;
        int           lat;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Result predicted directly from the operation's definition on the whole word
    function automatic exp_t model(input logic [W-1:0] op, input logic [2:0] fun, input int amt);
        exp_t         e;
        int           k;
        logic [W-1:0] r;
        bit           legal;
        legal = (fun == 3'd0) || (fun == 3'd1) || (fun == 3'd2);
`ifdef SHIFT_ROTATE_EN
        legal = legal || (fun == 3'd4) || (fun == 3'd5);
`endif
        e.err = 1'b0; e.carry = 1'b0; e.cyc = 0;
        if (!legal) begin
            e.out = '0; e.zero = 1'b1; e.err = 1'b1; e.lat = 1;
            return e;
        end
        if (fun == 3'd4 || fun == 3'd5) k = amt % W;
        else k = (amt > W) ? W : amt;
        case (fun)
            3'd0: begin
                r = (k >= W) ? '0 : op >> k;
                if (k > 0) e.carry = op[k-1];
            end
            3'd1: begin
                r = (k >= W) ? '0 : op << k;
                if (k > 0) e.carry = op[W-k];
            end
            3'd2: begin
                r = (k >= W) ? {W{op[W-1]}} : W'($signed(op) >>> k);
                if (k > 0) e.carry = op[k-1];
            end
            3'd4: begin
                r = (k == 0) ? op : ((op << k) | (op >> (W - k)));
                if (k > 0) e.carry = r[0];
            end
            default: begin
                r = (k == 0) ? op : ((op >> k) | (op << (W - k)));
                if (k > 0) e.carry = r[W-1];
            end
        endcase
        e.out = r;
        e.zero = (r == '0);
        e.lat = (k == 0) ? 1 : k + 1;
        return e;
    endfunction

    // Single compare process: any visible result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, exp_q[0].cyc);
                    seen = 1'b1;
                end
                chk("shift_out", {16'd0, shift_out}, {16'd0, exp_q[0].out});
                chk("carry_flag", {31'd0, carry_flag}, {31'd0, exp_q[0].carry});
                chk("zero_flag", {31'd0, zero_flag}, {31'd0, exp_q[0].zero});
                chk("shift_err", {31'd0, shift_err}, {31'd0, exp_q[0].err});
                chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (out_ready || !shift_en) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic scramble();
        in1 = W'($urandom);
        in2 = W'($urandom);
        src_sel = 1'($urandom);
        shift_fun = 3'($urandom);
        shift_amt = AW'($urandom);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = in_ready;
        if (!ok) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // abort_done: drop shift_en while the result is held instead of taking it with out_ready
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                          input logic [2:0] fun, input logic [AW-1:0] amt, input int hold,
                          input bit abort_done);
        exp_t e;
        int   n;
        bit   ok;
        tick();
        in1 = a; in2 = b; src_sel = sel; shift_fun = fun; shift_amt = amt; in_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        e = model(sel ? b : a, fun, int'(amt));
        e.cyc = cyc + e.lat;
        exp_q.push_back(e);
        tick();
        scramble();
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            chk("result_timeout", {31'd0, out_valid}, 32'd1);
            exp_q.delete();
            seen = 1'b0;
            in_valid = 1'b0;
            return;
        end
        repeat (hold) tick();
        if (abort_done) begin
            shift_en = 1'b0;
            tick();
            in_valid = 1'b0;
            chk("done_abort_valid", {31'd0, out_valid}, 32'd0);
            shift_en = 1'b1;
        end else begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    // Accept, then drop shift_en on BUSY cycle j (1 = first cycle after accept); no result may appear
    task automatic do_busy_abort(input logic [W-1:0] a, input logic [2:0] fun,
                                 input logic [AW-1:0] amt, input int j);
        bit ok;
        tick();
        in1 = a; src_sel = 1'b0; shift_fun = fun; shift_amt = amt; in_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        tick();
        scramble();
        repeat (j - 1) tick();
        shift_en = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("busy_abort_in_ready_low", {31'd0, in_ready}, 32'd0);
        shift_en = 1'b1;
        #1;
        chk("busy_abort_back_to_idle", {31'd0, in_ready}, 32'd1);
        repeat (12) tick();
        chk("busy_abort_no_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_shift_out"}, {16'd0, shift_out}, 32'd0);
        chk({tag, "_flags"}, {28'd0, carry_flag, zero_flag, shift_err, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   ok;
        int   r;
        logic [2:0] funs [8];
        funs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        // Literal expectations that pin the model
        e = model(16'h8001, 3'b000, 1);
        chk("pin_srl_out", {16'd0, e.out}, 32'h4000);
        chk("pin_srl_carry_lat", {e.carry, 31'(e.lat)}, 32'h8000_0002);
        e = model(16'h8000, 3'b010, 20);
        chk("pin_sra_out", {16'd0, e.out}, 32'hFFFF);
        chk("pin_sra_carry_lat", {e.carry, 31'(e.lat)}, 32'h8000_0011);
        e = model(16'h8001, 3'b100, 17);
`ifdef SHIFT_ROTATE_EN
        chk("pin_rol_out", {16'd0, e.out}, 32'h0003);
        chk("pin_rol_carry_lat", {e.carry, 31'(e.lat)}, 32'h8000_0002);
`else
        chk("pin_rol_illegal_out", {16'd0, e.out}, 32'h0);
        chk("pin_rol_illegal_err_lat", {e.err, 31'(e.lat)}, 32'h8000_0001);
`endif
        e = model(16'h1234, 3'b001, 0);
        chk("pin_sll0_out", {16'd0, e.out}, 32'h1234);
        chk("pin_sll0_carry_lat", {e.carry, 31'(e.lat)}, 32'h0000_0001);

        // Reset state and in_ready gating until the first edge after release
        #3;
        chk_outputs_zero("reset");
        tick();
        rst = 1'b1;
        #1;
        chk("in_ready_before_first_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("in_ready_after_first_edge", {31'd0, in_ready}, 32'd1);

        // Directed corner cases
        do_txn(16'h8001, 16'h0000, 1'b0, 3'b000, 5'd1, 0, 1'b0);
        do_txn(16'h0000, 16'h8000, 1'b1, 3'b010, 5'd20, 1, 1'b0);
        do_txn(16'h8001, 16'h0000, 1'b0, 3'b100, 5'd17, 0, 1'b0);
        do_txn(16'h1234, 16'hFFFF, 1'b0, 3'b001, 5'd0, 5, 1'b0);
        do_txn(16'hABCD, 16'h0000, 1'b0, 3'b011, 5'd3, 0, 1'b0);
        do_txn(16'hABCD, 16'h5555, 1'b1, 3'b110, 5'd7, 1, 1'b0);
        do_txn(16'hF00F, 16'h0000, 1'b0, 3'b001, 5'd16, 0, 1'b0);
        do_txn(16'h7FFF, 16'h0000, 1'b0, 3'b010, 5'd31, 0, 1'b0);
        do_txn(16'h0001, 16'h0000, 1'b0, 3'b101, 5'd16, 0, 1'b0);
        do_busy_abort(16'h00FF, 3'b001, 5'd8, 3);
        do_txn(16'h1357, 16'h0000, 1'b0, 3'b000, 5'd4, 2, 1'b1);

        // Reset asserted while BUSY
        tick();
        in1 = 16'hA5A5; src_sel = 1'b0; shift_fun = 3'b001; shift_amt = 5'd8; in_valid = 1'b1;
        wait_ready(ok);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk_outputs_zero("mid_busy_reset");
        tick();
        rst = 1'b1;
        #1;
        chk("in_ready_after_mid_reset", {31'd0, in_ready}, 32'd0);
        repeat (20) tick();
        chk("no_valid_after_mid_reset", {31'd0, out_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 70; i++) begin
            logic [W-1:0]  a;
            logic [W-1:0]  b;
            logic          sel;
            logic [2:0]    fun;
            logic [AW-1:0] amt;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = '0;
            sel = 1'($urandom);
            fun = funs[$urandom_range(0, 7)];
            amt = AW'($urandom);
            r = $urandom_range(0, 9);
            e = model(a, fun, int'(amt));
            if (r == 9 && e.lat > 2)
                do_busy_abort(a, fun, amt, $urandom_range(1, e.lat - 1));
            else
                do_txn(a, b, sel, fun, amt, $urandom_range(0, 3), r == 8);
        end

        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
